// File: rtl/pkt_gen.sv
// pkt_gen: queues software metadata words and expands each into a header-plus-seeded-body packet stream.
module pkt_gen #(
    parameter int FIFO_DEPTH = 8,
    parameter logic [1:0] PORT_ID = 2'd0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          meta_en,
    input  logic [31:0]                   meta_in,
    input  logic                          enable,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [31:0]                   out_data,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [1:0]                    out_dest,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_cnt,
    output logic [15:0]                   pkt_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state, state_n;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_n;
    logic [31:0]   head;
    logic [5:0]    len, idx;
    logic [23:0]   seed;
    logic          push, pop, adv, done, can_start;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || $bits(PORT_ID) != 2) begin : g_bad_params
        $error("pkt_gen: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    assign head      = mem[rd_ptr];
    assign can_start = fifo_level != '0 && enable;
    // Zero-length words are never queued; a full FIFO drops even if a pop frees a slot this cycle.
    assign push      = meta_en && meta_in[29:24] != 6'd0 && !fifo_full;
    assign level_n   = fifo_level + LW'(push) - LW'(pop);

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        adv     = 1'b0;
        done    = 1'b0;
        if (state == IDLE) begin
            pop     = can_start;
            state_n = can_start ? SEND : IDLE;
        end else if (out_valid && out_ready) begin
            adv     = !out_eop;
            done    = out_eop;
            pop     = out_eop && can_start;
            state_n = (out_eop && !can_start) ? IDLE : SEND;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= meta_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            fifo_full  <= 1'b0;
            drop_cnt   <= '0;
            pkt_cnt    <= '0;
        end else begin
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_level <= level_n;
            fifo_full  <= level_n == LW'(FIFO_DEPTH);
            drop_cnt   <= drop_cnt + 8'(meta_en && !push && drop_cnt != 8'hFF);
            pkt_cnt    <= pkt_cnt + 16'(done);
        end
    end

    // idx is the index of the next body word to present.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_dest  <= '0;
            len       <= '0;
            idx       <= '0;
            seed      <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= head;
            out_sop   <= 1'b1;
            out_eop   <= head[29:24] == 6'd1;
            out_dest  <= head[31:30];
            len       <= head[29:24];
            idx       <= 6'd1;
            seed      <= head[23:0];
        end else if (adv) begin
            out_data  <= {8'h00, seed + 24'(idx)};
            out_sop   <= 1'b0;
            out_eop   <= idx == len - 6'd1;
            idx       <= idx + 6'd1;
        end else if (done) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pkt_gen.sv
// tb_pkt_gen: directed and randomized checks of pkt_gen against a packet-expansion reference model.
module tb_pkt_gen;
    localparam int DEPTH = 8;

    logic        clk = 1'b0, reset = 1'b1, meta_en = 1'b0, enable = 1'b0, out_ready = 1'b0;
    logic [31:0] meta_in = '0;
    logic        out_valid, out_sop, out_eop, fifo_full;
    logic [31:0] out_data;
    logic [1:0]  out_dest;
    logic [3:0]  fifo_level;
    logic [7:0]  drop_cnt;
    logic [15:0] pkt_cnt;

    int vectors = 0, miscompares = 0, cyc = 0;
    logic [35:0] got_q[$], exp_q[$];
    int          got_t[$];

    pkt_gen #(.FIFO_DEPTH(DEPTH), .PORT_ID(2'd0)) dut (
        .clk(clk), .reset(reset), .meta_en(meta_en), .meta_in(meta_in), .enable(enable),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop),
        .out_eop(out_eop), .out_dest(out_dest), .fifo_full(fifo_full), .fifo_level(fifo_level),
        .drop_cnt(drop_cnt), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Words are {sop, eop, dest, data}, captured just before the edge that accepts them.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            got_q.push_back({out_sop, out_eop, out_dest, out_data});
            got_t.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task push(input logic [31:0] w);
        meta_en = 1'b1;
        meta_in = w;
        tick();
        meta_en = 1'b0;
    endtask

    task automatic expand(input logic [31:0] m);
        int l = int'(m[29:24]);
        for (int i = 0; i < l; i++) begin
            logic [31:0] d;
            d = (i == 0) ? m : {8'h00, m[23:0] + 24'(i)};
            exp_q.push_back({i == 0, i == l - 1, m[31:30], d});
        end
    endtask

    task clear_q;
        got_q.delete();
        got_t.delete();
        exp_q.delete();
    endtask

    task wait_words(input int n, input int budget);
        int c;
        c = 0;
        while (got_q.size() < n && c < budget) begin
            tick();
            c++;
        end
    endtask

    function automatic int eops();
        int n = 0;
        foreach (got_q[k]) if (got_q[k][34]) n++;
        return n;
    endfunction

    task test_reset;
        reset = 1'b1;
        enable = 1'b1;
        meta_en = 1'b1;
        meta_in = 32'h4300_0010;
        tick();
        meta_en = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({out_valid, out_data, out_sop, out_eop, out_dest, fifo_full, fifo_level, drop_cnt, pkt_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got %h required 0",
                     {out_valid, out_data, out_sop, out_eop, out_dest, fifo_full, fifo_level, drop_cnt, pkt_cnt});
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_release: valid=%b level=%0d required 0/0", out_valid, fifo_level);
        end
    endtask

    task test_single;
        clear_q();
        enable = 1'b1;
        out_ready = 1'b1;
        expand(32'h4300_0010);
        push(32'h4300_0010);
        vectors++;
        if (fifo_level !== 4'd1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_push_latency: level=%0d valid=%b required 1/0", fifo_level, out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h4300_0010 || out_sop !== 1'b1 || out_dest !== 2'd1) begin
            miscompares++;
            $display("FAIL single_header_latency: valid=%b data=%h sop=%b dest=%0d required 1/43000010/1/1",
                     out_valid, out_data, out_sop, out_dest);
        end
        wait_words(3, 20);
        vectors++;
        if (got_q.size() != 3) begin
            miscompares++;
            $display("FAIL single_count: got %0d words required 3", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL single_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (got_q.size() == 3 && got_t[2] - got_t[0] != 2) begin
            miscompares++;
            $display("FAIL single_throughput: span %0d cycles required 2", got_t[2] - got_t[0]);
        end
        vectors++;
        if (pkt_cnt !== 16'd1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pkt_cnt: pkt_cnt=%0d valid=%b required 1/0", pkt_cnt, out_valid);
        end
    endtask

    task test_backpressure;
        clear_q();
        out_ready = 1'b0;
        expand(32'h4300_0010);
        push(32'h4300_0010);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({out_valid, out_sop, out_eop, out_dest, out_data} !== {1'b1, exp_q[1]}) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got %h required %h", i,
                         {out_valid, out_sop, out_eop, out_dest, out_data}, {1'b1, exp_q[1]});
            end
        end
        out_ready = 1'b1;
        wait_words(3, 20);
        repeat (3) tick();
        vectors++;
        if (got_q.size() != 3) begin
            miscompares++;
            $display("FAIL bp_count: got %0d handshakes required 3", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL bp_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task test_overflow;
        logic [7:0]  d0;
        logic [15:0] p0;
        logic [31:0] m;
        clear_q();
        enable = 1'b0;
        out_ready = 1'b1;
        d0 = drop_cnt;
        p0 = pkt_cnt;
        for (int i = 0; i < 10; i++) begin
            m = {2'(i), 6'd2, 24'(i * 1000)};
            if (i < DEPTH) expand(m);
            push(m);
        end
        vectors++;
        if (fifo_level !== 4'(DEPTH) || fifo_full !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_level: level=%0d full=%b required %0d/1", fifo_level, fifo_full, DEPTH);
        end
        vectors++;
        if (drop_cnt !== d0 + 8'd2) begin
            miscompares++;
            $display("FAIL ovf_drop: got %0d required %0d", drop_cnt, d0 + 8'd2);
        end
        vectors++;
        if (got_q.size() != 0) begin
            miscompares++;
            $display("FAIL ovf_disabled_output: got %0d words required 0", got_q.size());
        end
        enable = 1'b1;
        wait_words(16, 40);
        vectors++;
        if (got_q.size() != 16) begin
            miscompares++;
            $display("FAIL ovf_count: got %0d words required 16", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL ovf_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (got_q.size() == 16 && got_t[15] - got_t[0] != 15) begin
            miscompares++;
            $display("FAIL ovf_back_to_back: span %0d cycles required 15", got_t[15] - got_t[0]);
        end
        vectors++;
        if (pkt_cnt !== p0 + 16'd8 || fifo_level !== 4'd0 || fifo_full !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_final: pkt_cnt=%0d level=%0d full=%b required %0d/0/0",
                     pkt_cnt, fifo_level, fifo_full, p0 + 16'd8);
        end
    endtask

    task test_zero_and_single_word;
        logic [7:0] d0;
        clear_q();
        d0 = drop_cnt;
        push(32'h0000_0005);
        repeat (3) tick();
        vectors++;
        if (drop_cnt !== d0 + 8'd1 || got_q.size() != 0 || fifo_level !== 4'd0) begin
            miscompares++;
            $display("FAIL zero_len: drop=%0d words=%0d level=%0d required %0d/0/0",
                     drop_cnt, got_q.size(), fifo_level, d0 + 8'd1);
        end
        expand(32'h8100_00FF);
        push(32'h8100_00FF);
        wait_words(1, 10);
        repeat (2) tick();
        vectors++;
        if (got_q.size() != 1) begin
            miscompares++;
            $display("FAIL l1_count: got %0d words required 1", got_q.size());
        end else begin
            vectors++;
            if (got_q[0] !== exp_q[0]) begin
                miscompares++;
                $display("FAIL l1_word: got %h required %h", got_q[0], exp_q[0]);
            end
        end
    endtask

    task test_seed_wrap;
        clear_q();
        expand(32'h03FF_FFFF);
        push(32'h03FF_FFFF);
        wait_words(3, 20);
        vectors++;
        if (got_q.size() != 3) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d words required 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL wrap_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
            vectors++;
            if (got_q[1][31:0] !== 32'h0 || got_q[2][31:0] !== 32'h1) begin
                miscompares++;
                $display("FAIL wrap_body: got %h %h required 00000000 00000001", got_q[1][31:0], got_q[2][31:0]);
            end
        end
    endtask

    task test_random;
        logic [7:0]  d0;
        logic [15:0] p0;
        logic [31:0] m;
        int acc, zeros, len;
        clear_q();
        d0 = drop_cnt;
        p0 = pkt_cnt;
        acc = 0;
        zeros = 0;
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom_range(3) != 0);
            enable = ($urandom_range(9) != 0);
            if ($urandom_range(2) == 0) begin
                len = ($urandom_range(8) == 0) ? 0 : int'($urandom_range(1, 10));
                m = {2'($urandom), 6'(len), 24'($urandom)};
                if (len == 0) begin
                    zeros++;
                    meta_en = 1'b1;
                    meta_in = m;
                end else if (acc - eops() < DEPTH) begin
                    acc++;
                    expand(m);
                    meta_en = 1'b1;
                    meta_in = m;
                end
            end
            tick();
            meta_en = 1'b0;
            vectors++;
            if (fifo_level > 4'(DEPTH)) begin
                miscompares++;
                $display("FAIL rand_level: got %0d exceeds %0d", fifo_level, DEPTH);
            end
        end
        enable = 1'b1;
        out_ready = 1'b1;
        wait_words(exp_q.size(), 1000);
        tick();
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL rand_count: got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL rand_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (drop_cnt !== d0 + 8'(zeros) || pkt_cnt !== p0 + 16'(acc)) begin
            miscompares++;
            $display("FAIL rand_counters: drop=%0d pkt=%0d required %0d/%0d",
                     drop_cnt, pkt_cnt, d0 + 8'(zeros), p0 + 16'(acc));
        end
    endtask

    task test_drop_saturate;
        clear_q();
        for (int i = 0; i < 260; i++) push({8'h40, 24'(i)});
        tick();
        vectors++;
        if (drop_cnt !== 8'd255 || got_q.size() != 0) begin
            miscompares++;
            $display("FAIL drop_saturate: drop=%0d words=%0d required 255/0", drop_cnt, got_q.size());
        end
    endtask

    task test_enable_reset;
        logic [15:0] p0;
        clear_q();
        enable = 1'b1;
        out_ready = 1'b1;
        p0 = pkt_cnt;
        expand(32'hC500_0100);
        push(32'hC500_0100);
        push(32'h4600_0200);
        enable = 1'b0;
        wait_words(5, 20);
        repeat (4) tick();
        vectors++;
        if (got_q.size() != 5 || out_valid !== 1'b0 || fifo_level !== 4'd1 || pkt_cnt !== p0 + 16'd1) begin
            miscompares++;
            $display("FAIL en_hold: words=%0d valid=%b level=%0d pkt=%0d required 5/0/1/%0d",
                     got_q.size(), out_valid, fifo_level, pkt_cnt, p0 + 16'd1);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL en_word%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        push(32'h8200_0300);
        vectors++;
        if (fifo_level !== 4'd2) begin
            miscompares++;
            $display("FAIL en_queue: level=%0d required 2", fifo_level);
        end
        enable = 1'b1;
        repeat (2) tick();
        vectors++;
        if (out_valid !== 1'b1 || out_sop !== 1'b0 || out_data !== 32'h0000_0201) begin
            miscompares++;
            $display("FAIL rst_midpkt_setup: valid=%b sop=%b data=%h required 1/0/00000201",
                     out_valid, out_sop, out_data);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if ({out_valid, out_data, out_sop, out_eop, out_dest, fifo_full, fifo_level, drop_cnt, pkt_cnt} !== '0) begin
            miscompares++;
            $display("FAIL rst_midpkt: got %h required 0",
                     {out_valid, out_data, out_sop, out_eop, out_dest, fifo_full, fifo_level, drop_cnt, pkt_cnt});
        end
        reset = 1'b0;
        repeat (3) tick();
        vectors++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
            miscompares++;
            $display("FAIL rst_fifo_flush: valid=%b level=%0d required 0/0", out_valid, fifo_level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_zero_and_single_word();
        test_seed_wrap();
        test_random();
        test_drop_saturate();
        test_enable_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
